ook_demod: RTL
==============

Name: ook_demod

Overview:
- OOK receiver: the counterpart of the team's DDS OOK transmitter.
- Takes 8-bit offset-binary ADC samples of the on/off-keyed carrier.
- Detects the carrier envelope per fixed sample window and applies hysteresis.
- Slices UART-style frames (start = carrier on, 8 data bits LSB first with on=1, stop = carrier off) into bytes for the host side.

Parameters:
- DATA_W, 8: sample and envelope width.
- MIDSCALE, 128: zero level of the offset-binary sample.
- WIN_LEN, 64: valid samples per envelope window. Must be at least one carrier period; power of two not required.
- THRESH_HI, 48: envelope >= this sets carrier_det.
- THRESH_LO, 32: envelope < this clears carrier_det. Requires THRESH_LO < THRESH_HI.
- WINS_PER_BIT, 8: envelope windows per OOK bit. Must be even and >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_in  in  DATA_W  ADC sample, offset binary
- sample_valid  in  1  sample_in valid this cycle
- rx_byte  out  8  last correctly framed byte
- byte_valid  out  1  one-cycle pulse when rx_byte updates
- framing_err  out  1  one-cycle pulse on bad stop bit
- carrier_det  out  1  hysteresis carrier-present flag
- env_level  out  DATA_W  peak magnitude of last completed window
- busy  out  1  high in any FSM state other than IDLE

Behaviour:
- Reset (async, active-high):
  - Clears all outputs to 0 and FSM to IDLE.
  - Clears sample counter, peak register and bit/window counters.
- Magnitude:
  - mag = sample_in - MIDSCALE if sample_in >= MIDSCALE, else MIDSCALE - sample_in.
  - Result fits in DATA_W (sample 0 gives 128).
- Envelope (valid samples only; cycles with sample_valid=0 change nothing):
  - peak <= max(peak, mag); sample counter increments.
  - On the valid sample with counter == WIN_LEN-1:
    - env_level <= max(peak, mag); peak <= 0; counter <= 0.
    - win_tick (internal) pulses high for one cycle, registered on the same edge.
- carrier_det: updated on the same edge as env_level.
  - New envelope >= THRESH_HI -> 1.
  - New envelope < THRESH_LO -> 0.
  - Otherwise holds its previous value.
- The FSM samples win_tick and carrier_det one cycle after they are registered.
- FSM states and transitions:
  - IDLE: on a 0->1 edge of carrier_det (registered previous value kept) -> START, win_cnt <= 0. A carrier already high on entry to IDLE does not start a frame.
  - START: count win_ticks to WINS_PER_BIT/2 (mid-start-bit).
    - carrier_det=1 -> DATA, bit_cnt <= 0, win_cnt <= 0.
    - carrier_det=0 -> IDLE (glitch, no output pulse).
  - DATA: every WINS_PER_BIT win_ticks, shift carrier_det in at MSB and shift right, so the first bit lands at bit 0 after 8 shifts. bit_cnt increments; after the 8th sample -> STOP.
  - STOP: after WINS_PER_BIT win_ticks, sample carrier_det.
    - 0 -> rx_byte <= shift register, byte_valid pulse.
    - 1 -> framing_err pulse, rx_byte unchanged.
    - Either way -> IDLE.
- Timing: with frame start detected at window-end k, the sampling points fall on windows:
  - k+WINS_PER_BIT/2 (start check)
  - +WINS_PER_BIT*i for i=1..8 (data bits)
  - +9*WINS_PER_BIT (stop bit)
- Output latency: byte_valid/framing_err assert 2 clk cycles after the stop-bit window's final valid sample edge.
- byte_valid and framing_err are mutually exclusive and never asserted more than one cycle.
- A reset mid-frame discards the partial byte; no pulse is produced.

Decomposition:
- Package ook_pkg holds:
  - MIDSCALE constant
  - default THRESH_HI / THRESH_LO / WIN_LEN / WINS_PER_BIT
  - FSM state enumeration {IDLE, START, DATA, STOP}
- Sub-module ook_envelope (magnitude, peak-hold window, hysteresis comparator) outputs env_level, carrier_det and win_tick.
- ook_demod instantiates ook_envelope and adds the frame FSM.

Test Plan:
1. Carrier stimulus: defaults, continuous sample_valid, DDS-generated sine of amplitude 127 with period 64 samples, sent as frame 0xA5 (windows on/off per bit, stop off for 8 windows).
   -> env_level=127 during on-windows, rx_byte=0xA5, single byte_valid pulse, framing_err never high.
2. Glitch: carrier on for 2 windows then off for 100 windows.
   -> START aborts, busy returns low, no byte_valid or framing_err.
3. Bad stop bit: frame 0x3C with the carrier held on through the stop bit.
   -> framing_err single pulse, rx_byte keeps previous value (0 after reset), no byte_valid.
4. Hysteresis: amplitude-40 sine from reset.
   -> env_level=40, carrier_det stays 0.
   Then amplitude 127 for 1 window (carrier_det=1), then amplitude 40.
   -> carrier_det remains 1 until amplitude 20 gives envelope 20 < 32, then 0.
5. Sample gaps: repeat scenario 1 with sample_valid high only every 3rd cycle.
   -> identical rx_byte=0xA5. Window boundaries count valid samples only; rx_byte and byte_valid unchanged on invalid cycles.
6. Reset mid-frame: assert rst asynchronously mid data bit 4, release, then send 0x81.
   -> all outputs 0 during reset, no pulse for the aborted frame, then rx_byte=0x81 with one byte_valid.

Source files
------------

// File: rtl/ook_pkg.sv
// ook_pkg -- shared constants and types for the OOK receiver.
//   OOK_MIDSCALE      : zero level of the offset-binary ADC sample
//   OOK_WIN_LEN       : default valid samples per envelope window
//   OOK_THRESH_HI/LO  : default hysteresis thresholds on the envelope
//   OOK_WINS_PER_BIT  : default envelope windows per OOK bit
//   ook_state_e       : frame slicer FSM states
package ook_pkg;

    localparam int OOK_MIDSCALE     = 128;
    localparam int OOK_WIN_LEN      = 64;
    localparam int OOK_THRESH_HI    = 48;
    localparam int OOK_THRESH_LO    = 32;
    localparam int OOK_WINS_PER_BIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ook_state_e;

endpackage

// File: rtl/ook_demod_envelope.sv
// ook_envelope -- carrier envelope detector.
//   Rectifies each valid offset-binary sample around MIDSCALE, holds the peak
//   over WIN_LEN valid samples and, at each window end, publishes the peak as
//   env_level and updates the hysteresis flag carrier_det.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   sample_in     : ADC sample (offset binary), qualified by sample_valid
//   env_level     : peak magnitude of the last completed window
//   carrier_det   : hysteresis carrier-present flag
//   win_tick      : one-cycle pulse, registered with env_level/carrier_det
module ook_envelope
    import ook_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MIDSCALE  = OOK_MIDSCALE,
    parameter int WIN_LEN   = OOK_WIN_LEN,
    parameter int THRESH_HI = OOK_THRESH_HI,
    parameter int THRESH_LO = OOK_THRESH_LO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] env_level,
    output logic              carrier_det,
    output logic              win_tick
);

    localparam int                CNT_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [DATA_W-1:0] MID      = DATA_W'(MIDSCALE);
    localparam logic [DATA_W-1:0] THR_HI   = DATA_W'(THRESH_HI);
    localparam logic [DATA_W-1:0] THR_LO   = DATA_W'(THRESH_LO);

    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] peak_max;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [DATA_W-1:0] peak_d, peak_q;
    logic [DATA_W-1:0] env_d, env_q;
    logic              cdet_d, cdet_q;
    logic              tick_d, tick_q;

    always_comb begin
        // |sample - MIDSCALE| always fits in DATA_W for offset binary
        mag      = (sample_in >= MID) ? (sample_in - MID) : (MID - sample_in);
        peak_max = (mag > peak_q) ? mag : peak_q;

        cnt_d  = cnt_q;
        peak_d = peak_q;
        env_d  = env_q;
        cdet_d = cdet_q;
        tick_d = 1'b0;

        if (sample_valid) begin
            if (cnt_q == CNT_LAST) begin
                // window closes: the current sample still counts toward it
                cnt_d  = '0;
                peak_d = '0;
                env_d  = peak_max;
                tick_d = 1'b1;
                if (peak_max >= THR_HI) begin
                    cdet_d = 1'b1;
                end else if (peak_max < THR_LO) begin
                    cdet_d = 1'b0;
                end
            end else begin
                cnt_d  = cnt_q + 1'b1;
                peak_d = peak_max;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            peak_q <= '0;
            env_q  <= '0;
            cdet_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            peak_q <= peak_d;
            env_q  <= env_d;
            cdet_q <= cdet_d;
            tick_q <= tick_d;
        end
    end

    assign env_level   = env_q;
    assign carrier_det = cdet_q;
    assign win_tick    = tick_q;

endmodule

// File: rtl/ook_demod.sv
// ook_demod -- OOK receiver: envelope detector plus UART-style frame slicer.
//   Frame: start = carrier on, 8 data bits LSB first (on = 1), stop = carrier
//   off. Bits are sampled in the middle of each bit period, counted in
//   envelope windows.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   sample_in     : ADC sample (offset binary), qualified by sample_valid
//   rx_byte       : last correctly framed byte
//   byte_valid    : one-cycle pulse when rx_byte updates
//   framing_err   : one-cycle pulse when the stop bit sees carrier
//   carrier_det   : hysteresis carrier-present flag
//   env_level     : peak magnitude of the last completed window
//   busy          : slicer is inside a frame (state other than IDLE)
module ook_demod
    import ook_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int MIDSCALE     = OOK_MIDSCALE,
    parameter int WIN_LEN      = OOK_WIN_LEN,
    parameter int THRESH_HI    = OOK_THRESH_HI,
    parameter int THRESH_LO    = OOK_THRESH_LO,
    parameter int WINS_PER_BIT = OOK_WINS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [7:0]        rx_byte,
    output logic              byte_valid,
    output logic              framing_err,
    output logic              carrier_det,
    output logic [DATA_W-1:0] env_level,
    output logic              busy
);

    localparam int              WC_W     = (WINS_PER_BIT > 1) ? $clog2(WINS_PER_BIT) : 1;
    localparam logic [WC_W-1:0] WC_HALF  = WC_W'(WINS_PER_BIT / 2 - 1);
    localparam logic [WC_W-1:0] WC_FULL  = WC_W'(WINS_PER_BIT - 1);

    logic env_tick;
    logic env_cdet;

    ook_envelope #(
        .DATA_W    (DATA_W),
        .MIDSCALE  (MIDSCALE),
        .WIN_LEN   (WIN_LEN),
        .THRESH_HI (THRESH_HI),
        .THRESH_LO (THRESH_LO)
    ) u_env (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .env_level    (env_level),
        .carrier_det  (env_cdet),
        .win_tick     (env_tick)
    );

    assign carrier_det = env_cdet;

    // Slicer inputs are re-registered once; the extra stage also keeps the
    // previous carrier value for IDLE's rising-edge detect.
    logic       tick_s_d,  tick_s_q;
    logic       cdet_s_d,  cdet_s_q;
    logic       cdet_p_d,  cdet_p_q;

    ook_state_e        state_d, state_q;
    logic [WC_W-1:0]   win_cnt_d, win_cnt_q;
    logic [2:0]        bit_cnt_d, bit_cnt_q;
    logic [7:0]        shreg_d, shreg_q;
    logic [7:0]        rx_byte_d, rx_byte_q;
    logic              byte_valid_d, byte_valid_q;
    logic              framing_err_d, framing_err_q;
    logic              busy_d, busy_q;

    always_comb begin
        tick_s_d      = env_tick;
        cdet_s_d      = env_cdet;
        cdet_p_d      = cdet_s_q;

        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        rx_byte_d     = rx_byte_q;
        byte_valid_d  = 1'b0;
        framing_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // only a fresh 0->1 edge starts a frame, never a level
                if (cdet_s_q && !cdet_p_q) begin
                    state_d   = START;
                    win_cnt_d = '0;
                end
            end
            START: begin
                if (tick_s_q) begin
                    if (win_cnt_q == WC_HALF) begin
                        win_cnt_d = '0;
                        if (cdet_s_q) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = IDLE;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick_s_q) begin
                    if (win_cnt_q == WC_FULL) begin
                        win_cnt_d = '0;
                        shreg_d   = {cdet_s_q, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick_s_q) begin
                    if (win_cnt_q == WC_FULL) begin
                        win_cnt_d = '0;
                        state_d   = IDLE;
                        if (cdet_s_q) begin
                            framing_err_d = 1'b1;
                        end else begin
                            rx_byte_d    = shreg_q;
                            byte_valid_d = 1'b1;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // registered, but taken from the next state so it tracks state_q exactly
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_s_q      <= 1'b0;
            cdet_s_q      <= 1'b0;
            cdet_p_q      <= 1'b0;
            state_q       <= IDLE;
            win_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            rx_byte_q     <= '0;
            byte_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            tick_s_q      <= tick_s_d;
            cdet_s_q      <= cdet_s_d;
            cdet_p_q      <= cdet_p_d;
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            rx_byte_q     <= rx_byte_d;
            byte_valid_q  <= byte_valid_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign byte_valid  = byte_valid_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule
